logic16_pipe_chip: RTL

//   Two-stage pipelined 16-bit bitwise logic unit with valid/ready handshakes.

---
 rtl/logic16_pipe_chip_if.sv | 29 ++
 rtl/logic16_pipe_chip.sv | 85 ++++++++
 2 files changed

// File: rtl/logic16_pipe_chip_if.sv
// Handshake and data bundle for logic16_pipe_chip.
//   in_valid/in_ready   upstream operand handshake
//   a, b, op            operand word and operation select
//   out_valid/out_ready downstream result handshake
//   out, zr, ng         result word with zero and negative flags
// master: the side that produces operands and consumes results.
// slave:  the logic unit itself.
interface logic16_pipe_chip_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        zr;
    logic        ng;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, out, zr, ng
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, out, zr, ng
    );
endinterface

// File: rtl/logic16_pipe_chip.sv
// Two-stage pipelined 16-bit bitwise logic unit with valid/ready handshakes.
// Stage 1 registers the operands, stage 2 registers the result and its flags.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous reset, active-low
//   bus    logic16_pipe_chip_if.slave
//          op: 00=AND, 01=OR, 10=XOR, 11=NOT a (b ignored)
//          zr=1 when out==0, ng=out[15]
module logic16_pipe_chip (
    input  logic                 clk,
    input  logic                 rst_n,
    logic16_pipe_chip_if.slave   bus
);
    // The Hack word is fixed at 16 bits.
    localparam int WIDTH = 16;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [1:0]       s1_op;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_out;
    logic             s2_zr;
    logic             s2_ng;

    logic             s1_adv;
    logic             s2_adv;
    logic [WIDTH-1:0] result;

    // A stage may advance when it is empty or when the stage below moves.
    assign s2_adv = !s2_valid || bus.out_ready;
    assign s1_adv = !s1_valid || s2_adv;

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid;
    assign bus.out       = s2_out;
    assign bus.zr        = s2_zr;
    assign bus.ng        = s2_ng;

    // Built only from AND/OR/NOT; XOR is expanded into its sum-of-products form.
    always_comb begin
        result = '0;
        case (s1_op)
            2'b00:   result = s1_a & s1_b;
            2'b01:   result = s1_a | s1_b;
            2'b10:   result = (s1_a & ~s1_b) | (~s1_a & s1_b);
            default: result = ~s1_a;
        endcase
    end

    // Data registers only load with a valid word so idle cycles leave them quiet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= 2'b00;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_a  <= bus.a;
                s1_b  <= bus.b;
                s1_op <= bus.op;
            end
        end
    end

    // When stage 1 is empty the result registers keep their last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_out   <= '0;
            s2_zr    <= 1'b0;
            s2_ng    <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_out <= result;
                s2_zr  <= ~|result;
                s2_ng  <= result[WIDTH-1];
            end
        end
    end
endmodule
